// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle T0..T3 instruction control unit for the 16-bit CPU.
// Latches an instruction from din in T0. It then drives register-select codes with
// their enables, the ALU and bus strobes, and a one-cycle done pulse.
// Optional feature macro: CTRL_INSTR_COUNT_EN adds the instr_count retired-instruction counter.
module cpu_control_fsm #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] ir,
    output logic [3:0]        rin_bin,
    output logic              rin_en,
    output logic [3:0]        rout_bin,
    output logic              rout_en,
    output logic              din_out,
    output logic              a_in,
    output logic              g_in,
    output logic              g_out,
    output logic              addsub,
    output logic              done
`ifdef CTRL_INSTR_COUNT_EN
    ,
    output logic [15:0]       instr_count
`endif
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [3:0] OP_MV  = 4'd0;
    localparam logic [3:0] OP_MVI = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [4:0] NREG   = NUM_REGS[4:0];

    state_t            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;

    logic [3:0] opcode;
    logic [3:0] rx;
    logic [3:0] ry;
    logic       rx_ok;
    logic       ry_ok;
    logic       instr_legal;

    assign opcode = ir_q[15:12];
    assign rx     = ir_q[11:8];
    assign ry     = ir_q[7:4];
    assign ir     = ir_q;

    // Decode legality: known opcode and every register field it uses is in range
    always_comb begin
        rx_ok = ({1'b0, rx} < NREG);
        ry_ok = ({1'b0, ry} < NREG);
        case (opcode)
            OP_MV:          instr_legal = rx_ok && ry_ok;
            OP_MVI:         instr_legal = rx_ok;
            OP_ADD, OP_SUB: instr_legal = rx_ok && ry_ok;
            default:        instr_legal = 1'b0;
        endcase
    end

    // State and instruction register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state logic; ir loads only when a run request is accepted in T0
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            T0: begin
                if (run) begin
                    ir_d    = din;
                    state_d = T1;
                end
            end
            T1: begin
                if (instr_legal && (opcode == OP_ADD || opcode == OP_SUB)) begin
                    state_d = T2;
                end else begin
                    state_d = T0;
                end
            end
            T2:      state_d = T3;
            T3:      state_d = T0;
            default: state_d = T0;
        endcase
    end

    // Control outputs, purely from state and ir; register codes idle at their field values
    always_comb begin
        rin_bin  = rx;
        rin_en   = 1'b0;
        rout_bin = ry;
        rout_en  = 1'b0;
        din_out  = 1'b0;
        a_in     = 1'b0;
        g_in     = 1'b0;
        g_out    = 1'b0;
        addsub   = 1'b0;
        done     = 1'b0;
        case (state_q)
            T1: begin
                if (!instr_legal) begin
                    done = 1'b1;
                end else begin
                    case (opcode)
                        OP_MV: begin
                            rout_en = 1'b1;
                            rin_en  = 1'b1;
                            done    = 1'b1;
                        end
                        OP_MVI: begin
                            din_out = 1'b1;
                            rin_en  = 1'b1;
                            done    = 1'b1;
                        end
                        default: begin
                            rout_bin = rx;
                            rout_en  = 1'b1;
                            a_in     = 1'b1;
                        end
                    endcase
                end
            end
            T2: begin
                rout_en = 1'b1;
                g_in    = 1'b1;
                addsub  = (opcode == OP_SUB);
            end
            T3: begin
                g_out  = 1'b1;
                rin_en = 1'b1;
                done   = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef CTRL_INSTR_COUNT_EN
    logic [15:0] instr_count_q, instr_count_d;

    // Retired-instruction count, wraps naturally at 16 bits
    always_comb begin
        instr_count_d = done ? instr_count_q + 16'd1 : instr_count_q;
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count_q <= '0;
        end else begin
            instr_count_q <= instr_count_d;
        end
    end

    assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: per-cycle expected control vectors are
// queued when an instruction is issued and compared as the FSM steps through it.
module tb_cpu_control_fsm;

    localparam int NREGS = 8;

    logic        clk;
    logic        reset;
    logic        run;
    logic [15:0] din;
    logic [15:0] ir;
    logic [3:0]  rin_bin;
    logic        rin_en;
    logic [3:0]  rout_bin;
    logic        rout_en;
    logic        din_out;
    logic        a_in;
    logic        g_in;
    logic        g_out;
    logic        addsub;
    logic        done;
`ifdef CTRL_INSTR_COUNT_EN
    logic [15:0] instr_count;
`endif

    cpu_control_fsm #(
        .DATA_W   (16),
        .NUM_REGS (NREGS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .din      (din),
        .ir       (ir),
        .rin_bin  (rin_bin),
        .rin_en   (rin_en),
        .rout_bin (rout_bin),
        .rout_en  (rout_en),
        .din_out  (din_out),
        .a_in     (a_in),
        .g_in     (g_in),
        .g_out    (g_out),
        .addsub   (addsub),
        .done     (done)
`ifdef CTRL_INSTR_COUNT_EN
        ,
        .instr_count (instr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_ir;
    logic [15:0] exp_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // {rin_bin, rin_en, rout_bin, rout_en, din_out, a_in, g_in, g_out, addsub, done}
    function automatic logic [15:0] mk(input logic [3:0] rinb, input logic rin,
                                       input logic [3:0] routb, input logic rout,
                                       input logic dout, input logic ain, input logic gin,
                                       input logic gout, input logic as, input logic dn);
        return {rin ? rinb : 4'h0, rin, rout ? routb : 4'h0, rout, dout, ain, gin, gout, as, dn};
    endfunction

    function automatic logic [15:0] obs_vec();
        return mk(rin_bin, rin_en, rout_bin, rout_en, din_out, a_in, g_in, g_out, addsub, done);
    endfunction

    // Reference model: expected control vector for each cycle after the load
    task automatic push_model(input logic [15:0] instr);
        logic [3:0] op, rx, ry;
        bit         rxo, ryo, legal;
        op  = instr[15:12];
        rx  = instr[11:8];
        ry  = instr[7:4];
        rxo = (int'(rx) < NREGS);
        ryo = (int'(ry) < NREGS);
        legal = (op == 4'd0 && rxo && ryo) || (op == 4'd1 && rxo) ||
                ((op == 4'd2 || op == 4'd3) && rxo && ryo);
        if (!legal) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        end else if (op == 4'd0) begin
            exp_q.push_back(mk(rx, 1, ry, 1, 0, 0, 0, 0, 0, 1));
        end else if (op == 4'd1) begin
            exp_q.push_back(mk(rx, 1, 0, 0, 1, 0, 0, 0, 0, 1));
        end else begin
            exp_q.push_back(mk(0, 0, rx, 1, 0, 1, 0, 0, 0, 0));
            exp_q.push_back(mk(0, 0, ry, 1, 0, 0, 1, 0, op == 4'd3, 0));
            exp_q.push_back(mk(rx, 1, 0, 0, 0, 0, 0, 1, 0, 1));
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_strobes"}, 32'(obs_vec()), 32'h0);
        check_eq({tag, "_ir"}, 32'(ir), 32'(exp_ir));
`ifdef CTRL_INSTR_COUNT_EN
        check_eq({tag, "_count"}, 32'(instr_count), 32'(exp_cnt));
`endif
    endtask

    // Issue one instruction from T0 and score every following cycle up to done.
    // max_steps < queued steps leaves the remainder in the queue (used for mid-instruction reset).
    task automatic run_instr(input string name, input logic [15:0] instr, input logic [15:0] imm,
                             input bit hold_run, input int max_steps);
        logic [15:0] e;
        int          step;
        @(negedge clk);
        check_idle({name, "_pre"});
        din = instr;
        run = 1'b1;
        push_model(instr);
        @(posedge clk);
        #1;
        exp_ir = instr;
        run    = hold_run;
        din    = imm;
        step   = 0;
        while (exp_q.size() > 0 && step < max_steps) begin
            @(negedge clk);
            e = exp_q.pop_front();
            step++;
            check_eq($sformatf("%s_T%0d", name, step), 32'(obs_vec()), 32'(e));
            if (e[0]) exp_cnt = exp_cnt + 16'd1;
        end
        if (exp_q.size() == 0) @(posedge clk);
    endtask

    initial begin
        reset   = 1'b1;
        run     = 1'b0;
        din     = '0;
        exp_ir  = '0;
        exp_cnt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        reset = 1'b0;

        run_instr("mvi_r3",    16'h1300, 16'hBEEF, 1'b0, 8);
        run_instr("mv_r2_r5",  16'h0250, 16'h0000, 1'b0, 8);
        run_instr("sub_r1_r4", 16'h3140, 16'h0000, 1'b0, 8);
        run_instr("add_r5_r7", 16'h2570, 16'h0000, 1'b0, 8);
        run_instr("op7",       16'h7000, 16'h0000, 1'b0, 8);
        run_instr("mv_r9",     16'h0910, 16'h0000, 1'b0, 8);
        run_instr("mv_r2_r2",  16'h0220, 16'h0000, 1'b0, 8);
        run_instr("add_r7_r8", 16'h2780, 16'h0000, 1'b0, 8);
        run_instr("mvi_r8",    16'h1800, 16'h0000, 1'b0, 8);
        run_instr("mvi_r7",    16'h1700, 16'h1234, 1'b0, 8);
        // run held high with a different din through T1..T3: must not reload early
        run_instr("b2b_add",   16'h2340, 16'h0560, 1'b1, 8);
        run_instr("b2b_mv",    16'h0650, 16'h0120, 1'b1, 8);
        run_instr("b2b_sub",   16'h3610, 16'h0000, 1'b0, 8);

        // Reset during T2 of an add: the Rx write in T3 must never happen
        run_instr("rst_add",   16'h2120, 16'h0000, 1'b0, 2);
        exp_q.delete();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_ir  = '0;
        exp_cnt = '0;
        @(negedge clk);
        check_idle("post_rst");
        @(negedge clk);
        check_idle("post_rst2");

`ifdef CTRL_INSTR_COUNT_EN
        force dut.instr_count_q = 16'hFFFE;
        #1;
        release dut.instr_count_q;
        exp_cnt = 16'hFFFE;
        run_instr("wrap_a", 16'h0010, 16'h0000, 1'b0, 8);
        run_instr("wrap_b", 16'h7000, 16'h0000, 1'b0, 8);
        run_instr("wrap_c", 16'h2120, 16'h0000, 1'b0, 8);
        @(negedge clk);
        check_eq("wrap_count", 32'(instr_count), 32'h0001);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_ir  = '0;
        exp_cnt = '0;
        @(negedge clk);
        check_idle("cnt_rst");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
